// File: rtl/booth_iter_counter.sv
// Iteration sequencer for the Booth multiplier datapath: counts partial-product
// steps over a programmable operand length in radix-2 or radix-4 mode.
module booth_iter_counter #(
    parameter int CNT_W     = 6,
    parameter bit RADIX4_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             radix4,
    input  logic             en_pp,
    input  logic             abort,
    output logic [CNT_W-1:0] out,
    output logic [CNT_W:0]   bit_idx,
    output logic [CNT_W-1:0] total,
    output logic             busy,
    output logic             last,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] out_nxt, total_nxt;
    logic             step2, step2_nxt;   // 1 = two operand bits per iteration
    logic [CNT_W:0]   len_inc;

    // One extra bit so len = 2^CNT_W-1 rounds up without overflow.
    assign len_inc = {1'b0, len} + (CNT_W+1)'(1);

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        out_nxt   = out;
        total_nxt = total;
        step2_nxt = step2;

        if (start) begin
            state_nxt = S_RUN;
            out_nxt   = '0;
            step2_nxt = radix4 && RADIX4_EN;
            total_nxt = step2_nxt ? len_inc[CNT_W:1] : len;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (abort) begin
                        state_nxt = S_IDLE;
                    end else if (total == '0) begin
                        state_nxt = S_DONE;
                    end else if (en_pp) begin
                        out_nxt = out + CNT_W'(1);
                        if (out == total - CNT_W'(1)) begin
                            state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            out   <= '0;
            total <= '0;
            step2 <= 1'b0;
        end else begin
            state <= state_nxt;
            out   <= out_nxt;
            total <= total_nxt;
            step2 <= step2_nxt;
        end
    end

    // All flags decode registered values only.
    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);
    assign last    = busy && (total != '0) && (out == total - CNT_W'(1));
    assign bit_idx = step2 ? {out, 1'b0} : {1'b0, out};

endmodule

// File: tb/tb_booth_iter_counter.sv
// Self-checking bench for booth_iter_counter: directed vector table, long-length
// sequences and randomized traffic against a behavioural model.
module tb_booth_iter_counter;

    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset, start, radix4, en_pp, abort;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] out, total;
    logic [CNT_W:0]   bit_idx;
    logic             busy, last, done;

    int checks = 0;
    int errors = 0;

    // Behavioural model: operation in progress, pending done, counts as integers.
    bit m_run, m_done;
    int m_out, m_total, m_step;

    booth_iter_counter #(.CNT_W(CNT_W), .RADIX4_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .radix4(radix4),
        .en_pp(en_pp), .abort(abort), .out(out), .bit_idx(bit_idx),
        .total(total), .busy(busy), .last(last), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit  rs, st, r4, en, ab;
        int  ln;
        int  e_out, e_bit, e_tot;
        bit  e_busy, e_last, e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit rs, bit st, int ln, bit r4, bit en, bit ab,
                               int e_out, int e_bit, int e_tot,
                               bit e_busy, bit e_last, bit e_done);
        vec_t x;
        x.rs = rs; x.st = st; x.ln = ln; x.r4 = r4; x.en = en; x.ab = ab;
        x.e_out = e_out; x.e_bit = e_bit; x.e_tot = e_tot;
        x.e_busy = e_busy; x.e_last = e_last; x.e_done = e_done;
        return x;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit rs, input bit st, input int ln,
                                input bit r4, input bit en, input bit ab);
        if (rs) begin
            m_run = 0; m_done = 0; m_out = 0; m_total = 0; m_step = 1;
        end else if (st) begin
            m_run   = 1;
            m_done  = 0;
            m_step  = r4 ? 2 : 1;
            m_total = (ln + m_step - 1) / m_step;
            m_out   = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_run) begin
            if (ab) begin
                m_run = 0;
            end else if (m_total == 0) begin
                m_run = 0; m_done = 1;
            end else if (en) begin
                m_out++;
                if (m_out == m_total) begin
                    m_run = 0; m_done = 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic cyc(input bit rs, input bit st, input int ln,
                       input bit r4, input bit en, input bit ab);
        reset = rs; start = st; len = CNT_W'(ln); radix4 = r4; en_pp = en; abort = ab;
        @(posedge clk);
        model_update(rs, st, ln, r4, en, ab);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " out"},     int'(out),     m_out);
        check({tag, " bit_idx"}, int'(bit_idx), m_out * m_step);
        check({tag, " total"},   int'(total),   m_total);
        check({tag, " busy"},    int'(busy),    int'(m_run));
        check({tag, " last"},    int'(last),    int'(m_run && (m_out == m_total - 1)));
        check({tag, " done"},    int'(done),    int'(m_done));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; radix4 = 1'b0; en_pp = 1'b0; abort = 1'b0;

        //               rs st ln r4 en ab  out bit tot busy last done
        vecs.push_back(v(1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0));
        // Radix-2, len 8
        vecs.push_back(v(0, 1, 8, 0, 0, 0,  0, 0, 8,  1, 0, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(v(0, 0, 0, 0, 1, 0,  k, k, 8,  k < 8, k == 7, k == 8));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  8, 8, 8,  0, 0, 0));
        // Radix-4, odd length 7 -> 4 iterations
        vecs.push_back(v(0, 1, 7, 1, 0, 0,  0, 0, 4,  1, 0, 0));
        for (int k = 1; k <= 4; k++)
            vecs.push_back(v(0, 0, 0, 0, 1, 0,  k, 2*k, 4,  k < 4, k == 3, k == 4));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  4, 8, 4,  0, 0, 0));
        // Gapped enables then abort at out=2
        vecs.push_back(v(0, 1, 8, 0, 0, 0,  0, 0, 8,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  1, 1, 8,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  1, 1, 8,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  1, 1, 8,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  2, 2, 8,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 1,  2, 2, 8,  0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  2, 2, 8,  0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 1,  2, 2, 8,  0, 0, 0));
        // Restart at out=3 with len 4
        vecs.push_back(v(0, 1, 8, 0, 0, 0,  0, 0, 8,  1, 0, 0));
        for (int k = 1; k <= 3; k++)
            vecs.push_back(v(0, 0, 0, 0, 1, 0,  k, k, 8,  1, 0, 0));
        vecs.push_back(v(0, 1, 4, 0, 1, 0,  0, 0, 4,  1, 0, 0));
        for (int k = 1; k <= 4; k++)
            vecs.push_back(v(0, 0, 0, 0, 1, 0,  k, k, 4,  k < 4, k == 3, k == 4));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  4, 4, 4,  0, 0, 0));
        // start + abort + en_pp together: start wins; then reset mid-RUN
        vecs.push_back(v(0, 1, 8, 0, 0, 0,  0, 0, 8,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  1, 1, 8,  1, 0, 0));
        vecs.push_back(v(0, 1, 5, 0, 1, 1,  0, 0, 5,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  1, 1, 5,  1, 0, 0));
        vecs.push_back(v(1, 1, 9, 1, 1, 1,  0, 0, 0,  0, 0, 0));
        // Zero length: one RUN cycle, then done with out=0
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0, 0));
        // Abort during DONE is ignored
        vecs.push_back(v(0, 1, 1, 0, 0, 0,  0, 0, 1,  1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  1, 1, 1,  0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 1,  1, 1, 1,  0, 0, 0));

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            cyc(vecs[i].rs, vecs[i].st, vecs[i].ln, vecs[i].r4, vecs[i].en, vecs[i].ab);
            check({t, " out"},     int'(out),     vecs[i].e_out);
            check({t, " bit_idx"}, int'(bit_idx), vecs[i].e_bit);
            check({t, " total"},   int'(total),   vecs[i].e_tot);
            check({t, " busy"},    int'(busy),    int'(vecs[i].e_busy));
            check({t, " last"},    int'(last),    int'(vecs[i].e_last));
            check({t, " done"},    int'(done),    int'(vecs[i].e_done));
        end

        // Maximum length, radix-2: 63 iterations, bit_idx tops out at 63.
        cyc(0, 1, 63, 0, 0, 0);
        check("max2 total", int'(total), 63);
        for (int k = 1; k <= 63; k++) begin
            cyc(0, 0, 0, 0, 1, 0);
            check("max2 out",  int'(out),  k);
            check("max2 last", int'(last), int'(k == 62));
            check("max2 done", int'(done), int'(k == 63));
        end
        check("max2 bit_idx", int'(bit_idx), 63);

        // Maximum length, radix-4: 32 iterations, bit_idx reaches 64 (needs the extra bit).
        cyc(0, 1, 63, 1, 0, 0);
        check("max4 total", int'(total), 32);
        for (int k = 1; k <= 32; k++) cyc(0, 0, 0, 0, 1, 0);
        check("max4 done",    int'(done),    1);
        check("max4 out",     int'(out),     32);
        check("max4 bit_idx", int'(bit_idx), 64);
        cyc(0, 0, 0, 0, 0, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit rs, st, r4, en, ab;
            int ln;
            rs = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 11) == 0);
            ab = ($urandom_range(0, 24) == 0);
            en = ($urandom_range(0, 2) != 0);
            r4 = $urandom_range(0, 1) != 0;
            ln = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 9);
            cyc(rs, st, ln, r4, en, ab);
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
